spi_fl_prog_seq: RTL and testbench

- Command sequencer that sits directly upstream of the SPI flash master and drives its controller interface.
- Turns one program or erase request into the full flash sequence:
  1. WREN (06h).
  2. PAGE PROGRAM (02h) of one 32-bit word, or SECTOR ERASE (20h).
  3. RDSR (05h) polling until WIP clears.
- Gives the CPU-side peripheral a single request/done handshake for non-volatile writes.

---
 rtl/spi_fl_prog_seq_if.sv | 44 ++++
 rtl/spi_fl_prog_seq.sv | 171 +++++++++++++++++
 tb/tb_spi_fl_prog_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fl_prog_seq_if.sv
// Request handshake and SPI flash master controller bus of the program/erase sequencer.
// The master modport is the sequencer; the slave modport is the CPU side plus the flash master.
interface spi_fl_prog_seq_if;
  logic        req_valid;
  logic        req_erase;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        done;
  logic        error;
  logic [7:0]  status_out;
  logic [7:0]  m_command;
  logic [23:0] m_address;
  logic [31:0] m_data_in;
  logic [2:0]  m_commtype;
  logic [6:0]  m_ndata_bits;
  logic [3:0]  m_dummy_cycles;
  logic [9:0]  m_frame_struct;
  logic [1:0]  m_xipbit_en;
  logic [1:0]  m_spimode;
  logic        m_manualframe_en;
  logic        m_validflag;
  logic        m_tready;
  logic        m_validflag_out;
  logic [31:0] m_data_out;

  modport master (
    input  req_valid, req_erase, req_addr, req_wdata,
    output req_ready, done, error, status_out,
    output m_command, m_address, m_data_in, m_commtype, m_ndata_bits,
    output m_dummy_cycles, m_frame_struct, m_xipbit_en, m_spimode, m_manualframe_en,
    output m_validflag,
    input  m_tready, m_validflag_out, m_data_out
  );

  modport slave (
    output req_valid, req_erase, req_addr, req_wdata,
    input  req_ready, done, error, status_out,
    input  m_command, m_address, m_data_in, m_commtype, m_ndata_bits,
    input  m_dummy_cycles, m_frame_struct, m_xipbit_en, m_spimode, m_manualframe_en,
    input  m_validflag,
    output m_tready, m_validflag_out, m_data_out
  );
endinterface

// File: rtl/spi_fl_prog_seq.sv
// Turns one program/erase request into WREN, PAGE PROGRAM or SECTOR ERASE, then RDSR polling
// until WIP clears, driving the SPI flash master controller interface.
module spi_fl_prog_seq #(
  parameter logic [2:0]  CT_CMD    = 3'b000,
  parameter logic [2:0]  CT_ADDR   = 3'b001,
  parameter logic [2:0]  CT_TX     = 3'b011,
  parameter logic [2:0]  CT_RX     = 3'b010,
  parameter logic [15:0] MAX_POLLS = 16'd50000,
  parameter logic [7:0]  BUSY_TO   = 8'd16
) (
  input logic               clk,
  input logic               rst,
  spi_fl_prog_seq_if.master bus
);
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_WAIT, S_OP, S_OP_WAIT, S_RDSR, S_RDSR_WAIT, S_CHECK, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [23:0] addr;
    logic [31:0] data;
    logic [6:0]  nbits;
  } frame_t;

  function automatic frame_t mk_frame(input logic [7:0] cmd, input logic [2:0] ct,
                                      input logic [23:0] addr, input logic [31:0] data,
                                      input logic [6:0] nbits);
    frame_t f;
    f.cmd   = cmd;
    f.ct    = ct;
    f.addr  = addr;
    f.data  = data;
    f.nbits = nbits;
    return f;
  endfunction

  state_t      state;
  frame_t      frame;
  logic        erase_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic        seen_busy;
  logic [7:0]  busy_cnt;
  logic [15:0] poll_cnt;
  logic        ready;
  logic        done;
  logic        error;
  logic        vflag;
  logic [7:0]  status;
  logic        unused_data_hi;

  assign unused_data_hi = ^bus.m_data_out[31:8];

  assign bus.req_ready        = ready;
  assign bus.done             = done;
  assign bus.error            = error;
  assign bus.status_out       = status;
  assign bus.m_command        = frame.cmd;
  assign bus.m_address        = frame.addr;
  assign bus.m_data_in        = frame.data;
  assign bus.m_commtype       = frame.ct;
  assign bus.m_ndata_bits     = frame.nbits;
  assign bus.m_dummy_cycles   = 4'd0;
  assign bus.m_frame_struct   = 10'h0;
  assign bus.m_xipbit_en      = 2'b00;
  assign bus.m_spimode        = 2'b00;
  assign bus.m_manualframe_en = 1'b0;
  assign bus.m_validflag      = vflag;

  // Frame fields are loaded on entry to an issue state and held until the next step,
  // so they stay stable for the whole master transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      frame     <= '0;
      erase_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      seen_busy <= 1'b0;
      busy_cnt  <= '0;
      poll_cnt  <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      vflag     <= 1'b0;
      status    <= '0;
    end else begin
      done  <= 1'b0;
      vflag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            erase_q <= bus.req_erase;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready   <= 1'b0;
            error   <= 1'b0;
            frame   <= mk_frame(CMD_WREN, CT_CMD, '0, '0, 7'd0);
            state   <= S_WREN;
          end
        end
        S_WREN, S_OP, S_RDSR: begin
          if (bus.m_tready) begin
            vflag     <= 1'b1;
            seen_busy <= 1'b0;
            busy_cnt  <= '0;
            state     <= (state == S_WREN) ? S_WREN_WAIT :
                         (state == S_OP)   ? S_OP_WAIT   : S_RDSR_WAIT;
          end
        end
        S_WREN_WAIT, S_OP_WAIT, S_RDSR_WAIT: begin
          // Status capture precedes the move to CHECK even when both arrive together.
          if (state == S_RDSR_WAIT && bus.m_validflag_out) begin
            status <= bus.m_data_out[7:0];
          end
          if (!seen_busy) begin
            if (!bus.m_tready) begin
              seen_busy <= 1'b1;
            end else if (busy_cnt == BUSY_TO - 8'd1) begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              busy_cnt <= busy_cnt + 8'd1;
            end
          end else if (bus.m_tready) begin
            case (state)
              S_WREN_WAIT: begin
                frame <= erase_q ? mk_frame(CMD_SE, CT_ADDR, addr_q, '0, 7'd0)
                                 : mk_frame(CMD_PP, CT_TX, addr_q, wdata_q, 7'd32);
                state <= S_OP;
              end
              S_OP_WAIT: begin
                frame <= mk_frame(CMD_RDSR, CT_RX, '0, '0, 7'd8);
                state <= S_RDSR;
              end
              default: state <= S_CHECK;
            endcase
          end
        end
        S_CHECK: begin
          if (!status[0]) begin
            done  <= 1'b1;
            error <= 1'b0;
            state <= S_DONE;
          end else if (poll_cnt == MAX_POLLS - 16'd1) begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
            state    <= S_RDSR;
          end
        end
        S_DONE: begin
          poll_cnt <= '0;
          ready    <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_fl_prog_seq.sv
// Self-checking bench for spi_fl_prog_seq: flash master model, frame/result expectation model,
// per-cycle compare process and directed request scenarios.
module tb_spi_fl_prog_seq;
  localparam logic [2:0] CT_CMD = 3'b000;
  localparam logic [2:0] CT_ADDR = 3'b001;
  localparam logic [2:0] CT_TX = 3'b011;
  localparam logic [2:0] CT_RX = 3'b010;
  localparam int MAXP = 4;
  localparam int BUSY_LEN = 40;

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [23:0] addr;
    logic [31:0] data;
    logic [6:0]  nb;
    bit          ca;
    bit          cd;
  } exp_frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_fl_prog_seq_if bus ();

  spi_fl_prog_seq #(.MAX_POLLS(16'd4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  exp_frame_t exp_q[$];
  logic [7:0] resp[$];
  int         resp_idx = 0;
  bit         armed = 0;
  bit         exp_err = 0;
  logic [7:0] exp_status = 8'h00;
  logic [7:0] model_status = 8'h00;

  bit mode_never_busy = 0;
  bit hold_busy = 0;
  bit coinc = 0;

  int n_frames = 0;
  int n_rdsr = 0;
  int last_pulse_cyc = 0;
  bit in_frame = 0;
  bit saw_low = 0;
  bit prev_vf = 0;
  exp_frame_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Flash master model: tready drops 2 cycles after the pulse, stays low BUSY_LEN cycles.
  initial begin
    int  t;
    bit  active;
    bit  is_rdsr;
    int  rx_t;
    bus.m_tready = 1'b1;
    bus.m_validflag_out = 1'b0;
    bus.m_data_out = '0;
    active = 0;
    is_rdsr = 0;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_validflag_out = 1'b0;
      rx_t = coinc ? 2 + BUSY_LEN : 2 + BUSY_LEN - 1;
      if (mode_never_busy) begin
        bus.m_tready = 1'b1;
        active = 0;
      end else if (active) begin
        t++;
        if (is_rdsr && t == rx_t) begin
          bus.m_validflag_out = 1'b1;
          bus.m_data_out = {24'hA5C3E1, (resp_idx < resp.size()) ? resp[resp_idx] : resp[resp.size()-1]};
          resp_idx++;
        end
        if (t >= 2 && t < 2 + BUSY_LEN) bus.m_tready = 1'b0;
        else if (t >= 2 + BUSY_LEN) begin
          bus.m_tready = 1'b1;
          active = 0;
        end
      end else if (bus.m_validflag) begin
        active = 1;
        t = 0;
        is_rdsr = (bus.m_command == 8'h05);
        bus.m_tready = 1'b1;
      end else begin
        bus.m_tready = !hold_busy;
      end
    end
  end

  // Expected frame list and outcome for one request, from the flash command rules.
  task automatic arm(input bit erase, input logic [23:0] a, input logic [31:0] d);
    logic [7:0] r;
    exp_q.delete();
    exp_q.push_back('{8'h06, CT_CMD, 24'h0, 32'h0, 7'd0, 1'b0, 1'b0});
    if (erase) exp_q.push_back('{8'h20, CT_ADDR, a, 32'h0, 7'd0, 1'b1, 1'b0});
    else exp_q.push_back('{8'h02, CT_TX, a, d, 7'd32, 1'b1, 1'b1});
    for (int i = 0; i < MAXP; i++) begin
      r = (i < resp.size()) ? resp[i] : resp[resp.size()-1];
      exp_q.push_back('{8'h05, CT_RX, 24'h0, 32'h0, 7'd8, 1'b0, 1'b0});
      model_status = r;
      if (!r[0]) begin
        exp_err = 0;
        break;
      end
      if (i == MAXP - 1) exp_err = 1;
    end
    exp_status = model_status;
    resp_idx = 0;
    armed = 1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("dummy", bus.m_dummy_cycles, 0);
      chk("fstruct", bus.m_frame_struct, 0);
      chk("xip", bus.m_xipbit_en, 0);
      chk("spimode", bus.m_spimode, 0);
      chk("manual", bus.m_manualframe_en, 0);
      if (bus.m_validflag) begin
        chk("vf_tready", bus.m_tready, 1);
        chk("vf_single", prev_vf, 0);
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", bus.m_command, 8'hFF);
        end else begin
          cur = exp_q.pop_front();
          chk("f_cmd", bus.m_command, cur.cmd);
          chk("f_ct", bus.m_commtype, cur.ct);
          chk("f_ndata", bus.m_ndata_bits, cur.nb);
          if (cur.ca) chk("f_addr", bus.m_address, cur.addr);
          if (cur.cd) chk("f_data", bus.m_data_in, cur.data);
        end
        cur.cmd = bus.m_command;
        cur.ct = bus.m_commtype;
        cur.addr = bus.m_address;
        cur.data = bus.m_data_in;
        cur.nb = bus.m_ndata_bits;
        n_frames++;
        if (bus.m_command == 8'h05) n_rdsr++;
        last_pulse_cyc = cyc;
        in_frame = 1;
        saw_low = 0;
      end else if (in_frame) begin
        chk("hold_cmd", bus.m_command, cur.cmd);
        chk("hold_ct", bus.m_commtype, cur.ct);
        chk("hold_addr", bus.m_address, cur.addr);
        chk("hold_data", bus.m_data_in, cur.data);
        chk("hold_nb", bus.m_ndata_bits, cur.nb);
        if (!bus.m_tready) saw_low = 1;
        else if (saw_low) in_frame = 0;
      end
      if (bus.done) begin
        chk("done_armed", armed, 1);
        chk("done_error", bus.error, exp_err);
        chk("done_status", bus.status_out, exp_status);
        chk("done_frames_left", exp_q.size(), 0);
        armed = 0;
        in_frame = 0;
      end
      prev_vf = bus.m_validflag;
    end
  end

  task automatic do_req(input bit e, input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_erase = e;
    bus.req_addr = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("req_ready_low", bus.req_ready, 0);
    chk("error_cleared", bus.error, 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    chk(nm, got, 1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      if (n_frames >= target) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_wait", got, 1);
  endtask

  task automatic idle_after_done();
    @(negedge clk);
    chk("ready_after_done", bus.req_ready, 1);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.req_valid = 1'b0;
    bus.req_erase = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_vflag", bus.m_validflag, 0);
    chk("rst_status", bus.status_out, 8'h00);
    chk("rst_cmd", bus.m_command, 8'h00);
    chk("rst_addr", bus.m_address, 24'h0);
    chk("rst_data", bus.m_data_in, 32'h0);
    chk("rst_ct", bus.m_commtype, 3'b000);
    chk("rst_nb", bus.m_ndata_bits, 7'd0);
    rst = 1'b0;

    // Program, one busy poll then WIP clear.
    resp = '{8'h03, 8'h00};
    base = n_frames;
    arm(1'b0, 24'h5a5a11, 32'hA0A0A0A3);
    do_req(1'b0, 24'h5a5a11, 32'hA0A0A0A3);
    wait_done("prog_done", 1500);
    chk("prog_err_lit", bus.error, 0);
    chk("prog_status_lit", bus.status_out, 8'h00);
    chk("prog_frames_lit", n_frames - base, 4);
    idle_after_done();

    // Erase, WIP clear on first poll; status arrives together with tready return.
    resp = '{8'h00};
    coinc = 1;
    base = n_frames;
    arm(1'b1, 24'h555000, 32'h0);
    do_req(1'b1, 24'h555000, 32'hDEADBEEF);
    wait_done("erase_done", 1000);
    chk("erase_err_lit", bus.error, 0);
    chk("erase_frames_lit", n_frames - base, 3);
    idle_after_done();
    coinc = 0;

    // Poll timeout with WIP stuck at 1.
    resp = '{8'h01};
    base = n_rdsr;
    arm(1'b0, 24'h000100, 32'h12345678);
    do_req(1'b0, 24'h000100, 32'h12345678);
    wait_done("poll_to_done", 2000);
    chk("poll_to_err_lit", bus.error, 1);
    chk("poll_to_status_lit", bus.status_out, 8'h01);
    chk("poll_to_rdsr_lit", n_rdsr - base, 4);
    idle_after_done();

    // Master never goes busy: busy timeout 16 cycles after the pulse.
    mode_never_busy = 1;
    exp_q.delete();
    exp_q.push_back('{8'h06, CT_CMD, 24'h0, 32'h0, 7'd0, 1'b0, 1'b0});
    exp_err = 1;
    exp_status = model_status;
    armed = 1;
    do_req(1'b0, 24'h000200, 32'h0);
    wait_done("busy_to_done", 200);
    chk("busy_to_err_lit", bus.error, 1);
    chk("busy_to_latency", cyc - last_pulse_cyc, 16);
    idle_after_done();
    mode_never_busy = 0;
    repeat (2) @(negedge clk);

    // Issue gated by a busy master; a second request mid-sequence is dropped.
    hold_busy = 1;
    repeat (3) @(negedge clk);
    resp = '{8'h00};
    base = n_frames;
    arm(1'b0, 24'h0abcde, 32'h0F0F0F0F);
    do_req(1'b0, 24'h0abcde, 32'h0F0F0F0F);
    repeat (8) @(negedge clk);
    chk("gate_no_pulse", n_frames - base, 0);
    hold_busy = 0;
    wait_frames(base + 1, 50);
    bus.req_valid = 1'b1;
    bus.req_erase = 1'b1;
    bus.req_addr = 24'h123456;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done("gate_done", 1000);
    chk("gate_frames_lit", n_frames - base, 3);
    idle_after_done();
    repeat (60) @(negedge clk);
    chk("gate_no_extra", n_frames - base, 3);

    // Reset in the middle of the PROGRAM transaction, then a clean request.
    resp = '{8'h00};
    base = n_frames;
    arm(1'b0, 24'h777777, 32'h55AA55AA);
    do_req(1'b0, 24'h777777, 32'h55AA55AA);
    wait_frames(base + 2, 200);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    armed = 0;
    in_frame = 0;
    prev_vf = 0;
    model_status = 8'h00;
    @(negedge clk);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_vflag", bus.m_validflag, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_status", bus.status_out, 8'h00);
    rst = 1'b0;
    resp = '{8'h00};
    arm(1'b0, 24'h010203, 32'hCAFEF00D);
    do_req(1'b0, 24'h010203, 32'hCAFEF00D);
    wait_done("post_rst_done", 1500);
    chk("post_rst_err_lit", bus.error, 0);
    idle_after_done();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
